traffic_sched: RTL and testbench

TRAFFIC_SCHED -- requirements
Module: traffic_sched

---
 rtl/traffic_sched.sv | 143 ++++++++++++++
 tb/tb_traffic_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sched.sv
// Two-way traffic light scheduler with tick-paced phases and a flashing-yellow night mode.
// Define TRAFFIC_PED_EN to build in the pedestrian request/acknowledge logic.
module traffic_sched #(
    parameter int unsigned G_TIME    = 9,
    parameter int unsigned Y_TIME    = 3,
    parameter int unsigned PED_SHORT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night,
    output logic [5:0] lights,
    output logic [3:0] count,
    output logic [2:0] phase,
    output logic       ped_ack
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        EW_G  = 3'd2,
        EW_Y  = 3'd3,
        NIGHT = 3'd4
    } state_t;

    localparam logic [3:0] G_LEN = 4'(G_TIME);
    localparam logic [3:0] Y_LEN = 4'(Y_TIME);
    localparam logic [3:0] P_LEN = 4'(PED_SHORT);

    state_t     state;
    state_t     state_nx;
    logic [3:0] count_nx;
    logic       flash;
    logic       flash_nx;
    logic [5:0] lights_nx;

`ifdef TRAFFIC_PED_EN
    logic ped_pending;
    logic served;

    // A request is served on the transition into either yellow phase.
    assign served = ped_pending && (state_nx != state) &&
                    ((state_nx == NS_Y) || (state_nx == EW_Y));

    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            ped_ack <= served;
            if (state == NIGHT)
                ped_pending <= 1'b0;
            else
                ped_pending <= ped_req | (ped_pending & ~served);
        end
    end
`else
    localparam logic ped_pending = 1'b0;
    logic unused_ped;

    assign unused_ped = ped_req;
    assign ped_ack    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        count_nx = count;
        flash_nx = flash;
        if (tick) begin
            if ((state != NIGHT) && night) begin
                state_nx = NIGHT;
                count_nx = '0;
                flash_nx = 1'b1;
            end else begin
                case (state)
                    NS_G, EW_G: begin
                        if (count == 4'd1) begin
                            state_nx = (state == NS_G) ? NS_Y : EW_Y;
                            count_nx = Y_LEN;
                        end else if (ped_pending && (count > P_LEN)) begin
                            count_nx = P_LEN;
                        end else begin
                            count_nx = count - 4'd1;
                        end
                    end
                    NS_Y, EW_Y: begin
                        if (count == 4'd1) begin
                            state_nx = (state == NS_Y) ? EW_G : NS_G;
                            count_nx = G_LEN;
                        end else begin
                            count_nx = count - 4'd1;
                        end
                    end
                    NIGHT: begin
                        if (!night) begin
                            state_nx = NS_G;
                            count_nx = G_LEN;
                            flash_nx = 1'b0;
                        end else begin
                            flash_nx = ~flash;
                        end
                    end
                    default: begin
                        state_nx = NS_G;
                        count_nx = G_LEN;
                        flash_nx = 1'b0;
                    end
                endcase
            end
        end
    end

    // Lights are decoded from the next state so the registered output matches phase.
    always_comb begin
        lights_nx = 6'b001_100;
        case (state_nx)
            NS_G:    lights_nx = 6'b001_100;
            NS_Y:    lights_nx = 6'b010_100;
            EW_G:    lights_nx = 6'b100_001;
            EW_Y:    lights_nx = 6'b100_010;
            NIGHT:   lights_nx = flash_nx ? 6'b010_010 : 6'b000_000;
            default: lights_nx = 6'b001_100;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= NS_G;
            count  <= G_LEN;
            flash  <= 1'b0;
            lights <= 6'b001_100;
        end else begin
            state  <= state_nx;
            count  <= count_nx;
            flash  <= flash_nx;
            lights <= lights_nx;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_sched.sv
// Scoreboard bench for traffic_sched: stimulus queues expected outputs per cycle, a negedge monitor compares.
// Pedestrian expectations follow whether TRAFFIC_PED_EN is defined for the build.
module tb_traffic_sched;

`ifdef TRAFFIC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [5:0] lights;
    logic [3:0] count;
    logic [2:0] phase;
    logic       ped_ack;

    traffic_sched #(.G_TIME(9), .Y_TIME(3), .PED_SHORT(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .ped_req (ped_req),
        .night   (night),
        .lights  (lights),
        .count   (count),
        .phase   (phase),
        .ped_ack (ped_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] cnt;
        logic [5:0] lt;
        logic       ack;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         step = 0;
    logic [2:0] e_ph = 3'd0;
    logic [3:0] e_cnt = 4'd9;
    logic       e_fl = 1'b0;

    function automatic logic [5:0] lts(input logic [2:0] ph, input logic fl);
        case (ph)
            3'd0:    return 6'b001_100;
            3'd1:    return 6'b010_100;
            3'd2:    return 6'b100_001;
            3'd3:    return 6'b100_010;
            default: return fl ? 6'b010_010 : 6'b000_000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step++;
            checks++;
            if ({phase, count, lights, ped_ack} !== e) begin
                failures++;
                $display("FAIL step%0d: got phase=%0d count=%0d lights=%b ack=%b, expected phase=%0d count=%0d lights=%b ack=%b",
                         step, phase, count, lights, ped_ack, e.ph, e.cnt, e.lt, e.ack);
            end
        end
    end

    task automatic push(input logic ack);
        exp_t e;
        e = {e_ph, e_cnt, lts(e_ph, e_fl), ack};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic t, input logic p, input logic [2:0] ph,
                       input logic [3:0] cnt, input logic fl, input logic ack);
        tick = t;
        ped_req = p;
        @(posedge clk);
        e_ph = ph;
        e_cnt = cnt;
        e_fl = fl;
        push(ack);
        #1;
        tick = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic idle(input logic p);
        cyc(1'b0, p, e_ph, e_cnt, e_fl, 1'b0);
    endtask

    // One tick followed by a quiet cycle that must show ped_ack low again.
    task automatic tk(input logic p, input logic [2:0] ph, input logic [3:0] cnt,
                      input logic fl, input logic ack);
        cyc(1'b1, p, ph, cnt, fl, ack);
        idle(p);
    endtask

    task automatic adv(input int n, input logic p);
        for (int i = 0; i < n; i++) begin
            logic [2:0] ph;
            logic [3:0] cnt;
            if (e_cnt > 4'd1) begin
                ph = e_ph;
                cnt = e_cnt - 4'd1;
            end else begin
                ph = (e_ph == 3'd3) ? 3'd0 : e_ph + 3'd1;
                cnt = ph[0] ? 4'd3 : 4'd9;
            end
            tk(p, ph, cnt, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick = 1'b1;
        @(posedge clk);
        e_ph = 3'd0;
        e_cnt = 4'd9;
        e_fl = 1'b0;
        push(1'b0);
        #1;
        rst = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;

        // Full cycle; with pedestrian logic absent, ped_req is held high throughout
        do_reset;
        adv(24, !PED);

        // Pulse at count 7 truncates green to 2
        do_reset;
        tk(1'b0, 3'd0, 4'd8, 1'b0, 1'b0);
        tk(1'b0, 3'd0, 4'd7, 1'b0, 1'b0);
        idle(1'b1);
        tk(1'b0, 3'd0, PED ? 4'd2 : 4'd6, 1'b0, 1'b0);
        tk(1'b0, 3'd0, PED ? 4'd1 : 4'd5, 1'b0, 1'b0);
        tk(1'b0, PED ? 3'd1 : 3'd0, PED ? 4'd3 : 4'd4, 1'b0, PED);

        // Request coinciding with tick truncates only on the following tick
        do_reset;
        tk(1'b1, 3'd0, 4'd8, 1'b0, 1'b0);
        tk(1'b0, 3'd0, PED ? 4'd2 : 4'd7, 1'b0, 1'b0);

        // Request at count 2: no truncation; request in yellow shortens next green
        do_reset;
        adv(7, 1'b0);
        idle(1'b1);
        tk(1'b0, 3'd0, 4'd1, 1'b0, 1'b0);
        tk(1'b0, 3'd1, 4'd3, 1'b0, PED);
        idle(1'b1);
        tk(1'b0, 3'd1, 4'd2, 1'b0, 1'b0);
        tk(1'b0, 3'd1, 4'd1, 1'b0, 1'b0);
        tk(1'b0, 3'd2, 4'd9, 1'b0, 1'b0);
        tk(1'b0, 3'd2, PED ? 4'd2 : 4'd8, 1'b0, 1'b0);
        tk(1'b0, 3'd2, PED ? 4'd1 : 4'd7, 1'b0, 1'b0);
        tk(1'b0, PED ? 3'd3 : 3'd2, PED ? 4'd3 : 4'd6, 1'b0, PED);

        // Night mode entered from EW_G at count 5, flashing, then exit
        do_reset;
        adv(16, 1'b0);
        night = 1'b1;
        idle(1'b0);
        tk(1'b0, 3'd4, 4'd0, 1'b1, 1'b0);
        tk(1'b0, 3'd4, 4'd0, 1'b0, 1'b0);
        idle(1'b1);
        tk(1'b0, 3'd4, 4'd0, 1'b1, 1'b0);
        night = 1'b0;
        idle(1'b0);
        tk(1'b0, 3'd0, 4'd9, 1'b0, 1'b0);
        tk(1'b0, 3'd0, 4'd8, 1'b0, 1'b0);

        // Reset in EW_Y with a pending request clears it without an ack
        do_reset;
        adv(21, 1'b0);
        idle(1'b1);
        tk(1'b0, 3'd3, 4'd2, 1'b0, 1'b0);
        do_reset;
        adv(9, 1'b0);
        idle(1'b0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
